// File: rtl/wb_dma_arbiter.sv
// wb_dma_arbiter: shares the processor-board Wishbone bus between the VM2 CPU
// and NDMA DMA masters. The CPU is only pre-empted once its strobe is low, a
// DMA master is only released once its own strobe is low, and DMA tenure is
// bounded by MAXBURST (0 = unlimited). A one-cycle gap always returns the bus
// to the CPU between DMA tenures.
//
// Optional feature macro: DMA_ARB_RR_EN
//   defined   -> round-robin winner selection among requesting masters
//   undefined -> fixed priority, lowest master index wins
//
// Handshake: every requester keeps its strobe high until it sees its ack
// (Wishbone classic, cyc = stb). Ownership changes only while the owner's
// strobe is low; the shared ack is routed combinationally to the current
// owner and forced to 0 for everyone else.
module wb_dma_arbiter #(
  parameter int NDMA     = 2,
  parameter int MAXBURST = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [15:0]         cpu_adr_i,
  input  logic [15:0]         cpu_dat_i,
  input  logic                cpu_we_i,
  input  logic [1:0]          cpu_sel_i,
  input  logic                cpu_stb_i,
  output logic                cpu_ack_o,
  output logic                cpu_gnt_o,
  input  logic [NDMA-1:0]     dma_req_i,
  output logic [NDMA-1:0]     dma_gnt_o,
  input  logic [NDMA*16-1:0]  m_adr_i,
  input  logic [NDMA*16-1:0]  m_dat_i,
  input  logic [NDMA-1:0]     m_we_i,
  input  logic [NDMA*2-1:0]   m_sel_i,
  input  logic [NDMA-1:0]     m_stb_i,
  output logic [NDMA-1:0]     m_ack_o,
  output logic [15:0]         bus_adr_o,
  output logic [15:0]         bus_dat_o,
  output logic                bus_we_o,
  output logic [1:0]          bus_sel_o,
  output logic                bus_stb_o,
  input  logic                bus_ack_i,
  output logic [1:0]          dbg_state_o
);

  localparam int OW = (NDMA > 1) ? $clog2(NDMA) : 1;
  localparam int CW = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_PREEMPT = 2'd1,
    ST_DMA     = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic            cpu_gnt_q;
  logic [NDMA-1:0] dma_gnt_q;
  logic [OW-1:0]   win;
  logic            dma_enter;
  logic            burst_done;
  logic            dma_leave;

  // Fixed priority: the lowest requesting index wins.
  function automatic logic [OW-1:0] pick_fixed(input logic [NDMA-1:0] req);
    logic [OW-1:0] w;
    w = '0;
    for (int i = NDMA - 1; i >= 0; i--) begin
      if (req[i]) w = OW'(i);
    end
    return w;
  endfunction

  // Round robin: first requester found scanning upward (with wrap) from start.
  function automatic logic [OW-1:0] pick_rr(input logic [NDMA-1:0] req,
                                            input logic [OW-1:0]   start);
    logic [OW-1:0] w;
    int            idx;
    w   = '0;
    idx = 0;
    for (int i = NDMA - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NDMA) idx = idx - NDMA;
      if (req[idx]) w = OW'(idx);
    end
    return w;
  endfunction

  assign dma_enter  = (state_q == ST_PREEMPT) && (dma_req_i != '0) && !cpu_stb_i;
  assign burst_done = (MAXBURST != 0) && (cnt_q >= CW'(MAXBURST));
  assign dma_leave  = !m_stb_i[owner_q] && (!dma_req_i[owner_q] || burst_done);

`ifdef DMA_ARB_RR_EN
  logic [OW-1:0] rr_q;

  // Start of the next round-robin search; moves just past each new owner.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rr_q <= '0;
    end else if (dma_enter) begin
      rr_q <= (int'(win) == NDMA - 1) ? '0 : win + OW'(1);
    end
  end

  assign win = pick_rr(dma_req_i, rr_q);
`else
  assign win = pick_fixed(dma_req_i);
`endif

  // Ownership FSM with registered grants, owner index and burst counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_CPU;
      owner_q   <= '0;
      cnt_q     <= '0;
      cpu_gnt_q <= 1'b1;
      dma_gnt_q <= '0;
    end else begin
      case (state_q)
        ST_CPU: begin
          if (dma_req_i != '0) begin
            state_q   <= ST_PREEMPT;
            cpu_gnt_q <= 1'b0;
          end
        end
        ST_PREEMPT: begin
          if (dma_req_i == '0) begin
            state_q   <= ST_CPU;
            cpu_gnt_q <= 1'b1;
          end else if (!cpu_stb_i) begin
            state_q   <= ST_DMA;
            owner_q   <= win;
            cnt_q     <= '0;
            dma_gnt_q <= NDMA'(1) << win;
          end
        end
        ST_DMA: begin
          if (!burst_done) cnt_q <= cnt_q + CW'(1);
          if (dma_leave) begin
            state_q   <= ST_GAP;
            dma_gnt_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_CPU;
          cpu_gnt_q <= 1'b1;
        end
      endcase
    end
  end

  // Steer the owner's bus signals and route the shared ack back to it only.
  always_comb begin
    bus_adr_o = cpu_adr_i;
    bus_dat_o = cpu_dat_i;
    bus_we_o  = cpu_we_i;
    bus_sel_o = cpu_sel_i;
    bus_stb_o = cpu_stb_i;
    cpu_ack_o = 1'b0;
    m_ack_o   = '0;
    case (state_q)
      ST_CPU, ST_PREEMPT: cpu_ack_o = bus_ack_i;
      ST_DMA: begin
        bus_adr_o        = m_adr_i[16*int'(owner_q) +: 16];
        bus_dat_o        = m_dat_i[16*int'(owner_q) +: 16];
        bus_we_o         = m_we_i[owner_q];
        bus_sel_o        = m_sel_i[2*int'(owner_q) +: 2];
        bus_stb_o        = m_stb_i[owner_q];
        m_ack_o[owner_q] = bus_ack_i;
      end
      default: bus_stb_o = 1'b0;
    endcase
  end

  assign cpu_gnt_o   = cpu_gnt_q;
  assign dma_gnt_o   = dma_gnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Bench for wb_dma_arbiter (NDMA=2, MAXBURST=4): directed scenarios followed
// by randomized traffic, every cycle compared against a behavioural model of
// bus ownership kept here.
module tb_wb_dma_arbiter;

  localparam int N    = 2;
  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cpu_adr, cpu_dat;
  logic        cpu_we, cpu_stb;
  logic [1:0]  cpu_sel;
  logic [N-1:0]    req;
  logic [N*16-1:0] m_adr, m_dat;
  logic [N-1:0]    m_we, m_stb;
  logic [N*2-1:0]  m_sel;
  logic            bus_ack;

  logic        cpu_ack_o, cpu_gnt_o;
  logic [N-1:0] dma_gnt_o, m_ack_o;
  logic [15:0] bus_adr_o, bus_dat_o;
  logic        bus_we_o, bus_stb_o;
  logic [1:0]  bus_sel_o;
  logic [1:0]  dbg_state;

  wb_dma_arbiter #(.NDMA(N), .MAXBURST(MAXB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_we_i(cpu_we),
    .cpu_sel_i(cpu_sel), .cpu_stb_i(cpu_stb), .cpu_ack_o(cpu_ack_o),
    .cpu_gnt_o(cpu_gnt_o),
    .dma_req_i(req), .dma_gnt_o(dma_gnt_o),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(m_stb), .m_ack_o(m_ack_o),
    .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_stb_o(bus_stb_o), .bus_ack_i(bus_ack),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // who: -1 = CPU side (yielding says it has been asked to give the bus up),
  //      k >= 0 = DMA master k owns the bus, -2 = turnaround cycle.
  int who = -1;
  bit yielding = 1'b0;
  int tenure = 0;
  int last_served = -1;

  function automatic int pick(input logic [N-1:0] r);
    int c;
`ifdef DMA_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      c = (last_served + k) % N;
      if (r[c]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = k;
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      who = -1; yielding = 1'b0; tenure = 0; last_served = -1;
    end else if (who == -2) begin
      who = -1;
    end else if (who >= 0) begin
      if (!m_stb[who] && (!req[who] || tenure >= MAXB)) who = -2;
      else tenure++;
    end else if (yielding) begin
      if (req == '0) yielding = 1'b0;
      else if (!cpu_stb) begin
        who = pick(req); last_served = who; tenure = 0; yielding = 1'b0;
      end
    end else if (req != '0) begin
      yielding = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [15:0] e_adr, e_dat;
    logic        e_we, e_stb, e_cgnt, e_cack;
    logic [1:0]  e_sel;
    logic [N-1:0] e_gnt, e_mack;
    e_cgnt = (who == -1) && !yielding;
    e_gnt = '0; e_mack = '0; e_cack = 1'b0;
    e_adr = cpu_adr; e_dat = cpu_dat; e_we = cpu_we; e_sel = cpu_sel; e_stb = cpu_stb;
    if (who >= 0) begin
      e_gnt[who]  = 1'b1;
      e_mack[who] = bus_ack;
      e_adr = m_adr[16*who +: 16];
      e_dat = m_dat[16*who +: 16];
      e_we  = m_we[who];
      e_sel = m_sel[2*who +: 2];
      e_stb = m_stb[who];
    end else if (who == -1) begin
      e_cack = bus_ack;
    end else begin
      e_stb = 1'b0;
    end
    chk("cpu_gnt", cpu_gnt_o, e_cgnt);
    chk("dma_gnt", dma_gnt_o, e_gnt);
    chk("cpu_ack", cpu_ack_o, e_cack);
    chk("m_ack", m_ack_o, e_mack);
    chk("bus_stb", bus_stb_o, e_stb);
    if (who != -2) begin
      chk("bus_adr", bus_adr_o, e_adr);
      chk("bus_dat", bus_dat_o, e_dat);
      chk("bus_we", bus_we_o, e_we);
      chk("bus_sel", bus_sel_o, e_sel);
    end
  endtask

  // ---------------- driver ----------------
  // One bus cycle: check outputs mid-cycle, cross the edge, advance the model.
  task automatic cyc();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_inputs();
    cpu_adr = 16'($urandom); cpu_dat = 16'($urandom);
    cpu_we  = 1'($urandom);  cpu_sel = 2'($urandom);
    cpu_stb = ($urandom_range(0, 9) < 4);
    m_adr   = 32'($urandom); m_dat = 32'($urandom);
    m_we    = 2'($urandom);  m_sel = 4'($urandom);
    for (int k = 0; k < N; k++) begin
      if (req[k]) req[k] = ($urandom_range(0, 9) != 0);
      else        req[k] = ($urandom_range(0, 11) == 0);
      m_stb[k] = ($urandom_range(0, 9) < 6);
    end
    bus_ack = 1'($urandom);
    rst     = ($urandom_range(0, 199) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cpu_adr = '0; cpu_dat = '0; cpu_we = 1'b0; cpu_sel = 2'b11;
    cpu_stb = 1'b1; req = '0; m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0;
    m_stb = '0; bus_ack = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_edge();

    // reset state
    chk("rst_cpu_gnt", cpu_gnt_o, 1);
    chk("rst_dma_gnt", dma_gnt_o, 0);
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_bus_stb", bus_stb_o, 1);
    rst = 1'b0; cpu_stb = 1'b0; bus_ack = 1'b0;
    repeat (8) cyc();

    // CPU idle, master 0 requests and reads 0o1000
    req = 2'b01; cyc();
    chk("t1_cpu_gnt_drop", cpu_gnt_o, 0);
    chk("t1_no_gnt_yet", dma_gnt_o, 0);
    cyc();
    chk("t1_gnt", dma_gnt_o, 2'b01);
    m_adr[15:0] = 16'o1000; m_stb = 2'b01; #1;
    chk("t1_bus_adr", bus_adr_o, 16'o1000);
    cyc();
    bus_ack = 1'b1; #1;
    chk("t1_m_ack", m_ack_o, 2'b01);
    chk("t1_cpu_ack", cpu_ack_o, 0);
    cyc();
    bus_ack = 1'b0; req = 2'b00; m_stb = 2'b00; cpu_stb = 1'b1; cyc();
    chk("t1_gap_dma_gnt", dma_gnt_o, 0);
    chk("t1_gap_cpu_gnt", cpu_gnt_o, 0);
    chk("t1_gap_stb", bus_stb_o, 0);
    cpu_stb = 1'b0; cyc();
    chk("t1_cpu_back", cpu_gnt_o, 1);
    repeat (3) cyc();

    // CPU cycle in flight for 3 cycles when master 0 requests
    cpu_adr = 16'o2000; cpu_stb = 1'b1; req = 2'b01; cyc();
    chk("t2_preempt", cpu_gnt_o, 0);
    chk("t2_cpu_on_bus", bus_adr_o, 16'o2000);
    cyc();
    chk("t2_hold_1", dma_gnt_o, 0);
    bus_ack = 1'b1; #1;
    chk("t2_cpu_ack", cpu_ack_o, 1);
    cyc();
    chk("t2_hold_2", dma_gnt_o, 0);
    cpu_stb = 1'b0; bus_ack = 1'b0; cyc();
    chk("t2_gnt_after_stb_low", dma_gnt_o, 2'b01);
    req = 2'b00; repeat (3) cyc();

    // MAXBURST=4: master 1 keeps requesting and strobing
    req = 2'b10; m_stb = 2'b10; m_adr[31:16] = 16'o3000;
    for (int i = 0; i < 10 && dma_gnt_o != 2'b10; i++) cyc();
    chk("t3_gnt", dma_gnt_o, 2'b10);
    repeat (8) cyc();
    chk("t3_held_while_stb", dma_gnt_o, 2'b10);
    m_stb = 2'b00; cyc();
    chk("t3_gap", dma_gnt_o, 0);
    chk("t3_gap_cpu", cpu_gnt_o, 0);
    cyc();
    chk("t3_cpu_slot", cpu_gnt_o, 1);
    cyc();
    chk("t3_preempt_again", cpu_gnt_o, 0);
    req = 2'b00; repeat (3) cyc();

    // Both masters request constantly: tenure order
`ifdef DMA_ARB_RR_EN
    exp_q = '{2'b01, 2'b10, 2'b01};
`else
    exp_q = '{2'b01, 2'b01, 2'b01};
`endif
    req = 2'b11; m_stb = 2'b00;
    begin
      logic [N-1:0] prev;
      prev = dma_gnt_o;
      for (int i = 0; i < 40; i++) begin
        cyc();
        if (dma_gnt_o != '0 && prev == '0) obs_q.push_back(dma_gnt_o);
        prev = dma_gnt_o;
      end
    end
    chk("t4_tenures", (obs_q.size() >= 3), 1);
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk("t4_order", obs_q.pop_front(), exp_q.pop_front());

    // Reset in the middle of a DMA transfer
    req = 2'b01;
    for (int i = 0; i < 20 && dma_gnt_o != 2'b01; i++) cyc();
    chk("t5_gnt", dma_gnt_o, 2'b01);
    m_stb = 2'b01; bus_ack = 1'b1; cpu_stb = 1'b1; rst = 1'b1; cyc();
    chk("t5_cpu_gnt", cpu_gnt_o, 1);
    chk("t5_dma_gnt", dma_gnt_o, 0);
    chk("t5_m_ack", m_ack_o, 0);
    chk("t5_bus_stb", bus_stb_o, 1);
    rst = 1'b0; req = '0; m_stb = '0; bus_ack = 1'b0; cpu_stb = 1'b0;
    repeat (2) cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
